// File: rtl/dmem_pkg.sv
// Shared constants for the data memory / MMIO stage.
// MMIO register offsets and STATUS bit layout.
package dmem_pkg;

  localparam logic [3:0] OFF_LED    = 4'd0;
  localparam logic [3:0] OFF_TXDATA = 4'd1;
  localparam logic [3:0] OFF_STATUS = 4'd2;
  localparam logic [3:0] OFF_CYCLO  = 4'd3;
  localparam logic [3:0] OFF_CYCHI  = 4'd4;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_CNT_LSB = 2;
  localparam int ST_CNT_MSB = 4;
  localparam int ST_OVF     = 5;

  localparam int ST_CNT_W = ST_CNT_MSB - ST_CNT_LSB + 1;

  function automatic logic [ST_CNT_W-1:0] sat_cnt(
    input logic [7:0] c
  );
    logic [7:0] lim;
    lim = 8'((1 << ST_CNT_W) - 1);
    sat_cnt = (c > lim) ? lim[ST_CNT_W-1:0]
                        : c[ST_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Core data port plus TX byte stream handshake.
// master = core/consumer side, slave = memory stage.
interface data_mem_mmio_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] data_rom_addr;
  logic              data_write_en;
  logic [DATA_W-1:0] data_rom_write;
  logic [DATA_W-1:0] data_rom_read;
  logic [DATA_W-1:0] led_out;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output data_rom_addr,
    output data_write_en,
    output data_rom_write,
    output tx_ready,
    input  data_rom_read,
    input  led_out,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  data_rom_addr,
    input  data_write_en,
    input  data_rom_write,
    input  tx_ready,
    output data_rom_read,
    output led_out,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/data_mem_mmio_tx_fifo.sv
// Power-of-two TX FIFO with valid/ready drain side.
// Head reads 0 while empty so tx_data is clean after reset.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop;
  logic             push_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign valid = !empty;
  assign count = cnt_q;
  assign data  = empty ? '0 : mem_q[rd_q];

  assign pop     = valid && ready;
  // a full FIFO still accepts a push when the head leaves this cycle
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop)     rd_d = rd_q + PW'(1);
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory stage: RAM below MMIO_BASE, LED/TX/STATUS/cycle regs above.
// Cycle counter present only when DMEM_CYCLE_CNT_EN is defined.
module data_mem_mmio
  import dmem_pkg::*;
#(
  parameter int              ADDR_W    = 9,
  parameter int              DATA_W    = 16,
  parameter int              TX_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 9'h1F0
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_mmio_if.slave bus
);

  localparam int RAM_D = int'(MMIO_BASE);
  localparam int CW    = $clog2(TX_DEPTH) + 1;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] off_full;
  logic [3:0]        off;
  logic [DATA_W-1:0] wdata;
  logic              wr;
  logic              is_ram;
  logic              in_win;
  logic              sel_led, sel_tx, sel_st;
  logic              sel_lo, sel_hi;

  assign addr     = bus.data_rom_addr;
  assign wdata    = bus.data_rom_write;
  assign wr       = bus.data_write_en;
  assign off_full = addr - MMIO_BASE;
  assign off      = off_full[3:0];
  assign is_ram   = (addr < MMIO_BASE);
  assign in_win   = !is_ram && (off_full < ADDR_W'(16));
  assign sel_led  = in_win && (off == OFF_LED);
  assign sel_tx   = in_win && (off == OFF_TXDATA);
  assign sel_st   = in_win && (off == OFF_STATUS);
  assign sel_lo   = in_win && (off == OFF_CYCLO);
  assign sel_hi   = in_win && (off == OFF_CYCHI);

  logic [DATA_W-1:0] ram_q [RAM_D];

  always_ff @(posedge clk) begin
    if (wr && is_ram) ram_q[addr] <= wdata;
  end

  logic [DATA_W-1:0] led_q, led_d;
  logic              ovf_q, ovf_d;

  logic            f_full, f_empty, f_drop;
  logic [CW-1:0]   f_cnt;

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr && sel_tx),
    .push_data (wdata[7:0]),
    .ready     (bus.tx_ready),
    .data      (bus.tx_data),
    .valid     (bus.tx_valid),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_cnt),
    .drop      (f_drop)
  );

  always_comb begin
    led_d = led_q;
    ovf_d = ovf_q;
    if (wr && sel_led) led_d = wdata;
    if (wr && sel_st && wdata[ST_OVF]) ovf_d = 1'b0;
    // a dropped push wins over a same-cycle clear
    if (f_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      led_q <= led_d;
      ovf_q <= ovf_d;
    end
  end

  logic [31:0] cyc;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (wr && sel_lo) cyc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cyc = cyc_q;
`else
  assign cyc = '0;
`endif

  logic [DATA_W-1:0] status;

  always_comb begin
    status = '0;
    status[ST_EMPTY] = f_empty;
    status[ST_FULL]  = f_full;
    status[ST_CNT_MSB:ST_CNT_LSB] = sat_cnt(8'(f_cnt));
    status[ST_OVF]   = ovf_q;
  end

  logic [DATA_W-1:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ram:  rdata = ram_q[addr];
      sel_led: rdata = led_q;
      sel_st:  rdata = status;
      sel_lo:  rdata = DATA_W'(cyc[15:0]);
      sel_hi:  rdata = DATA_W'(cyc[31:16]);
      default: rdata = '0;
    endcase
  end

  assign bus.data_rom_read = rdata;
  assign bus.led_out       = led_q;

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Data-side memory stage directly downstream of the core's data port. It consumes data_rom_addr, data_rom_write and data_write_en, and returns data_rom_read in the same cycle for the single-cycle core.
- Backing RAM occupies the low address space.
- A small MMIO window at the top of the address space holds an LED register, a byte-wide TX FIFO with a valid/ready output handshake, a status register and a free-running cycle counter.

Parameters:
ADDR_W, 9, data address width (matches core data_rom_addr)
DATA_W, 16, data word width
TX_DEPTH, 4, TX FIFO entries (power of two, 2..16)
MMIO_BASE, 9'h1F0, first MMIO address; RAM spans 0..MMIO_BASE-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_rom_addr  input  ADDR_W  word address from core
data_write_en  input  1  write strobe from core
data_rom_write  input  DATA_W  write data from core
data_rom_read  output  DATA_W  read data to core, combinational from address
led_out  output  DATA_W  LED register contents
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts head when tx_valid && tx_ready

Behaviour:
- Reset is async assert and sync-free deassert. On reset: led_out=0, FIFO empty (tx_valid=0, tx_data=0), overflow flag=0, cycle counter=0. RAM contents are not reset.
- Reads are combinational, with zero latency from data_rom_addr. Writes take effect at the clk edge when data_write_en=1, and are visible to a read in the next cycle. A same-cycle read returns the old value.
- Memory map, with offsets from MMIO_BASE:
  - RAM (addr < MMIO_BASE): read/write word.
  - +0 LED: R/W, full 16 bits.
  - +1 TXDATA: write pushes data_rom_write[7:0]. Reads return 0.
  - +2 STATUS: read {10'b0, overflow[5], count[4:2], full[1], empty[0]}; count saturates at its field width. Writing with bit5=1 clears overflow; other bits are ignored.
  - +3 CYCLO: read counter[15:0]. Any write clears the whole 32-bit counter.
  - +4 CYCHI: read counter[31:16]. Writes are ignored.
  - +5..+15 reserved: read 0, writes ignored.
- Cycle counter increments every cycle and wraps 0xFFFFFFFF to 0. The clear write has priority over the increment, so the counter is 0 on the next cycle. There is no low/high snapshot; software reads CYCHI, then CYCLO, then CYCHI again.
- TX FIFO:
  - A pop occurs when tx_valid && tx_ready.
  - A push is accepted when count<TX_DEPTH, or when count==TX_DEPTH with a pop in the same cycle.
  - A push to a full FIFO with no pop is dropped and sets the sticky overflow flag.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo TX_DEPTH.
  - tx_data holds the head while tx_valid=1 and tx_ready=0, and is stable until popped.
  - If the overflow flag is set and cleared in the same cycle, it ends up set.
- Reset mid-operation: FIFO contents are discarded immediately, and tx_valid drops asynchronously.

Optional Feature:
DMEM_CYCLE_CNT_EN
- Defined: cycle counter is implemented as above.
- Undefined: no counter flops; CYCLO/CYCHI read 0 and writes to them are ignored. All other behaviour is identical.

Decomposition:
- Shared package dmem_pkg holds:
  - MMIO offset constants (LED=0, TXDATA=1, STATUS=2, CYCLO=3, CYCHI=4)
  - STATUS bit positions (EMPTY=0, FULL=1, CNT_LSB=2, CNT_MSB=4, OVF=5)
- One sub-module, tx_fifo: parameterised depth/width, push/pop, full/empty/count, with valid/ready output. The top level handles decode, read mux, LED, counter and overflow.

Test Plan:
- Reset, then write RAM[0x005]=0xBEEF; read 0x005 next cycle -> 0xBEEF. Same-cycle read of 0x005 during a write of 0x1234 -> old value 0xBEEF.
- Write LED 0xA5A5 -> led_out=0xA5A5 next cycle. Read 0x1F0 -> 0xA5A5. Assert rst_n=0 mid-cycle -> led_out=0 immediately.
- tx_ready=0; write TXDATA 0x11,0x22,0x33,0x44 -> STATUS=0x0012 (count 4, full). Fifth write 0x55 -> STATUS=0x0032 (overflow set). Write STATUS 0x0020 -> 0x0012.
- FIFO full with tx_ready=1 and a same-cycle push of 0x66 -> pop 0x11, count stays 4. Subsequent pops give 0x22,0x33,0x44,0x66, then tx_valid=0 and STATUS=0x0001.
- With DMEM_CYCLE_CNT_EN: write CYCLO; 10 cycles later read CYCLO=10, CYCHI=0. Force the counter to 0x0000FFFF -> next cycle CYCHI=1, CYCLO=0. Without the macro, both read 0.
- Read reserved address 0x1F9 -> 0. Write 0x1F9 then read RAM and all MMIO registers -> all unchanged.
